// File: rtl/inst_axi_bridge_if.sv
// -----------------------------------------------------------------------------
// inst_axi_bridge_if
//
// Purpose:
//   Bundles the AXI4 read-address and read-data channels that the instruction
//   fetch bridge uses to talk to the interconnect.
//
// Modports:
//   master - the bridge side: drives arid/araddr/arlen/arsize/arburst/arvalid
//            and rready; samples arready and rid/rdata/rresp/rlast/rvalid.
//   slave  - the interconnect side, the mirror image of master.
//
// Parameters:
//   ID_W - width of arid/rid.
// -----------------------------------------------------------------------------
interface inst_axi_bridge_if #(
   parameter int ID_W = 4
);

   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [7:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   // The bridge initiates reads, so it owns the address channel and rready.
   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   // The interconnect answers reads, so it owns arready and the data channel.
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );

endinterface

// File: rtl/inst_axi_bridge.sv
// -----------------------------------------------------------------------------
// inst_axi_bridge
//
// Purpose:
//   Converts fetch-stage instruction requests (enable + PC) into single-beat
//   AXI4 reads, returns the word to decode, stalls fetch until the word for
//   the current PC is available, and keeps the last word so a held PC does
//   not cause a re-fetch.
//
// Ports:
//   clk, resetn    - clock; synchronous active-low reset.
//   inst_req_en    - fetch request enable.
//   inst_req_addr  - virtual PC, stable while inst_stall is high.
//   flush          - exception/eret flush; throws away in-flight/held data.
//   inst_rdata     - held instruction word, meaningful when inst_hit is high.
//   inst_hit       - inst_rdata belongs to the current request.
//   inst_stall     - stall request to the hazard unit.
//   inst_bus_err   - the held word returned with a non-OKAY response.
//   axi            - AXI4 read channels (master modport).
//
// Build option:
//   INST_BRIDGE_ADDR_MAP_EN - when defined, araddr carries the MIPS fixed-map
//   physical address (kseg0/kseg1 fold to the low 512 MB); otherwise araddr
//   is the virtual PC unchanged.
// -----------------------------------------------------------------------------
module inst_axi_bridge #(
   parameter int ID_W   = 4,
   parameter int AXI_ID = 0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req_en,
   input  logic [31:0]         inst_req_addr,
   input  logic                flush,
   output logic [31:0]         inst_rdata,
   output logic                inst_hit,
   output logic                inst_stall,
   output logic                inst_bus_err,
   inst_axi_bridge_if.master   axi
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] reqAddr_q, reqAddr_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        holdValid_q, holdValid_d;
   logic [31:0] holdAddr_q, holdAddr_d;
   logic [31:0] holdData_q, holdData_d;
   logic        holdErr_q, holdErr_d;
   logic        discard_q, discard_d;
   logic        hit;
   logic        unusedAxiInputs;

   // A hit is only reported from IDLE so that a stale held word can never be
   // presented while a replacement fetch for the same PC is still in flight.
   assign hit = inst_req_en & holdValid_q & (holdAddr_q == inst_req_addr)
                & (state_q == IDLE) & ~flush;

   assign inst_hit     = hit;
   assign inst_stall   = inst_req_en & ~hit & ~flush;
   assign inst_rdata   = holdData_q;
   assign inst_bus_err = holdErr_q;

   // Fixed AXI attributes: one 32-bit incrementing beat with a constant ID.
   assign axi.arid    = ID_W'(AXI_ID);
   assign axi.arlen   = 8'd0;
   assign axi.arsize  = 3'b010;
   assign axi.arburst = 2'b01;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   // Only one beat is ever requested and responses are not ID-checked, so
   // rid and rlast carry no information the bridge needs.
   assign unusedAxiInputs = ^{axi.rid, axi.rlast};

   // Physical address translation. kseg0 and kseg1 both alias the low 512 MB,
   // which is just a matter of clearing the top three bits.
`ifdef INST_BRIDGE_ADDR_MAP_EN
   assign axi.araddr = (reqAddr_q[31:30] == 2'b10) ? {3'b000, reqAddr_q[28:0]}
                                                   : reqAddr_q;
`else
   assign axi.araddr = reqAddr_q;
`endif

   // State and holding registers. Reset abandons any transaction outright,
   // which is safe because the interconnect shares the same reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         reqAddr_q   <= 32'd0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         holdValid_q <= 1'b0;
         holdAddr_q  <= 32'd0;
         holdData_q  <= 32'd0;
         holdErr_q   <= 1'b0;
         discard_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         reqAddr_q   <= reqAddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         holdValid_q <= holdValid_d;
         holdAddr_q  <= holdAddr_d;
         holdData_q  <= holdData_d;
         holdErr_q   <= holdErr_d;
         discard_q   <= discard_d;
      end
   end

   // Next-state logic. A flush during AR cannot retract arvalid once raised,
   // so the transaction is allowed to finish and its data is thrown away via
   // the discard flag. A flush always wins over a new request in IDLE; the
   // fetch stage re-presents the PC the following cycle.
   always_comb begin
      state_d     = state_q;
      reqAddr_d   = reqAddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      holdValid_d = holdValid_q;
      holdAddr_d  = holdAddr_q;
      holdData_d  = holdData_q;
      holdErr_d   = holdErr_q;
      discard_d   = discard_q;

      case (state_q)
         IDLE: begin
            if (inst_req_en & ~hit & ~flush) begin
               reqAddr_d = inst_req_addr;
               arvalid_d = 1'b1;
               state_d   = AR;
            end
         end
         AR: begin
            if (flush) begin
               discard_d = 1'b1;
            end
            if (axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = R;
            end
         end
         R: begin
            if (axi.rvalid & rready_q) begin
               rready_d  = 1'b0;
               state_d   = IDLE;
               discard_d = 1'b0;
               if (~discard_q & ~flush) begin
                  holdData_d  = axi.rdata;
                  holdAddr_d  = reqAddr_q;
                  holdErr_d   = (axi.rresp != 2'b00);
                  holdValid_d = 1'b1;
               end
            end else if (flush) begin
               discard_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (flush) begin
         holdValid_d = 1'b0;
      end
   end

endmodule
